// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS data-memory responder.
// Optional build macro: MIPS_DMEM_ALIGN_CHECK_EN (see mips_dmem_responder).
package mips_mem_pkg;

    localparam int DATA_W          = 32;
    localparam int BE_W            = 4;
    localparam int CNT_W           = 4;
    localparam int DEF_DEPTH_WORDS = 256;
    localparam int DEF_WAIT_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Byte-lane merge used by the storage array.
    function automatic logic [DATA_W-1:0] lane_merge(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mips_dmem_array.sv
// Single-port synchronous word store with byte-lane writes.
// No reset: contents survive responder resets.
module mips_dmem_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= lane_merge(mem[addr], wdata, be);
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mips_dmem_responder.sv
// Request/response data-memory responder with fixed wait latency.
// Define MIPS_DMEM_ALIGN_CHECK_EN to fault misaligned word accesses.
module mips_dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [DATA_W-1:0] TestPort
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              q_we;
    logic [DATA_W-1:0] q_addr;
    logic [DATA_W-1:0] q_wdata;
    logic [BE_W-1:0]   q_be;
    logic              rd_ok;

    logic              accept;
    logic              go_resp;
    logic              s_we;
    logic [DATA_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic [BE_W-1:0]   s_be;
    logic              s_err;
    logic [DATA_W-1:0] arr_rdata;

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // With zero wait cycles the access uses the live request, else the latch.
    always_comb begin
        s_we    = q_we;
        s_addr  = q_addr;
        s_wdata = q_wdata;
        s_be    = q_be;
        if (state == IDLE) begin
            s_we    = req_we;
            s_addr  = req_addr;
            s_wdata = req_wdata;
            s_be    = req_be;
        end
    end

    always_comb begin
        s_err = (s_addr >> (AW + 2)) != '0;
`ifdef MIPS_DMEM_ALIGN_CHECK_EN
        s_err = s_err || (s_addr[1:0] != 2'b00);
`endif
    end

    assign go_resp = !rst &&
        ((accept && (WAIT_CYCLES == 0)) ||
         ((state == WAIT) && (cnt == '0)));

    mips_dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .en    (go_resp && !s_err),
        .we    (s_we),
        .be    (s_be),
        .addr  (s_addr[AW+1:2]),
        .wdata (s_wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            q_we       <= 1'b0;
            q_addr     <= '0;
            q_wdata    <= '0;
            q_be       <= '0;
            TestPort   <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            rd_ok      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        q_we     <= req_we;
                        q_addr   <= req_addr;
                        q_wdata  <= req_wdata;
                        q_be     <= req_be;
                        TestPort <= req_addr;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_W'(WAIT_CYCLES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        rd_ok      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (go_resp) begin
                resp_valid <= 1'b1;
                resp_err   <= s_err;
                rd_ok      <= !s_we && !s_err;
            end
        end
    end

    assign resp_rdata = rd_ok ? arr_rdata : '0;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Randomized self-checking bench for mips_dmem_responder.
// Instance u1 uses defaults; u0 uses WAIT_CYCLES=0, DEPTH_WORDS=16.
module tb_mips_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rv, rr, sel;
    logic        req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;

    logic        r1_rdy, r1_vld, r1_err, r0_rdy, r0_vld, r0_err;
    logic [31:0] r1_rd, r1_tp, r0_rd, r0_tp;

    wire         rdy_m  = sel ? r0_rdy : r1_rdy;
    wire         vld_m  = sel ? r0_vld : r1_vld;
    wire         err_m  = sel ? r0_err : r1_err;
    wire  [31:0] rd_m   = sel ? r0_rd  : r1_rd;
    wire  [31:0] tp_m   = sel ? r0_tp  : r1_tp;

    int nchk = 0;
    int nerr = 0;

    logic [31:0] mem1 [256];
    logic [31:0] mem0 [16];

    always #5 clk = ~clk;

    mips_dmem_responder u1 (
        .clk(clk), .rst(rst),
        .req_valid(rv && !sel), .req_ready(r1_rdy),
        .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(r1_vld), .resp_ready(rr && !sel),
        .resp_rdata(r1_rd), .resp_err(r1_err),
        .TestPort(r1_tp)
    );

    mips_dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst(rst),
        .req_valid(rv && sel), .req_ready(r0_rdy),
        .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(r0_vld), .resp_ready(rr && sel),
        .resp_rdata(r0_rd), .resp_err(r0_err),
        .TestPort(r0_tp)
    );

    // Reference: flat word arrays, range/alignment rules, lane merge.
    task automatic model(input bit s, input bit we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] b,
                         output logic [31:0] rd, output logic er);
        longint unsigned depth;
        int idx;
        logic [31:0] w;
        depth = s ? 16 : 256;
        er = (longint'(a) >= 4 * depth);
`ifdef MIPS_DMEM_ALIGN_CHECK_EN
        if (a[1:0] != 2'b00) er = 1'b1;
`endif
        rd = 32'h0;
        if (!er) begin
            idx = int'(a >> 2);
            w = s ? mem0[idx] : mem1[idx];
            if (we) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) w[8*i +: 8] = wd[8*i +: 8];
                if (s) mem0[idx] = w;
                else   mem1[idx] = w;
            end else begin
                rd = w;
            end
        end
    endtask

    task automatic xact(input bit s, input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] b,
                        input int hold,
                        output logic [31:0] rd, output logic er,
                        output int lat, output bit quiet,
                        output bit stable, output logic rdy_after);
        int n;
        @(negedge clk);
        sel = s; req_we = we; req_addr = a;
        req_wdata = wd; req_be = b; rv = 1'b1;
        #1;
        n = 0;
        while (rdy_m !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        @(posedge clk); #1;
        req_we = 1'($urandom); req_addr = $urandom;
        req_wdata = $urandom; req_be = 4'($urandom);
        lat = 0; quiet = 1'b1;
        forever begin
            @(negedge clk);
            lat++;
            if (rdy_m !== 1'b0) quiet = 1'b0;
            if (vld_m === 1'b1 || lat >= 40) break;
        end
        rd = rd_m; er = err_m; stable = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (vld_m !== 1'b1 || rd_m !== rd || err_m !== er || rdy_m !== 1'b0)
                stable = 1'b0;
        end
        rv = 1'b0; rr = 1'b1;
        @(posedge clk); #1;
        rr = 1'b0;
        @(negedge clk);
        rdy_after = rdy_m;
    endtask

    task automatic test_reset();
        rst = 1'b1; rv = 1'b0; rr = 1'b0; sel = 1'b0;
        req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nchk++; if (r1_rdy !== 1'b0) begin nerr++; $display("FAIL rst_ready got=%b want=0", r1_rdy); end
        nchk++; if (r1_vld !== 1'b0) begin nerr++; $display("FAIL rst_valid got=%b want=0", r1_vld); end
        nchk++; if (r1_err !== 1'b0) begin nerr++; $display("FAIL rst_err got=%b want=0", r1_err); end
        nchk++; if (r1_rd !== 32'h0) begin nerr++; $display("FAIL rst_rdata got=%h want=0", r1_rd); end
        nchk++; if (r1_tp !== 32'h0) begin nerr++; $display("FAIL rst_testport got=%h want=0", r1_tp); end
        nchk++; if (r0_vld !== 1'b0) begin nerr++; $display("FAIL rst_valid_w0 got=%b want=0", r0_vld); end
        rst = 1'b0;
        #1;
        nchk++; if (r1_rdy !== 1'b1) begin nerr++; $display("FAIL rst_release_ready got=%b want=1", r1_rdy); end
        nchk++; if (r0_rdy !== 1'b1) begin nerr++; $display("FAIL rst_release_ready_w0 got=%b want=1", r0_rdy); end
    endtask

    task automatic test_fill();
        logic [31:0] rd, erd, wd; logic er, eer, ra; int lat; bit q, st;
        for (int i = 0; i < 256; i++) begin
            wd = $urandom;
            model(1'b0, 1'b1, 32'(4*i), wd, 4'hF, erd, eer);
            xact(1'b0, 1'b1, 32'(4*i), wd, 4'hF, 0, rd, er, lat, q, st, ra);
            nchk++; if (er !== 1'b0 || rd !== 32'h0) begin nerr++; $display("FAIL fill_w%0d err=%b rdata=%h want err=0 rdata=0", i, er, rd); end
        end
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            model(1'b1, 1'b1, 32'(4*i), wd, 4'hF, erd, eer);
            xact(1'b1, 1'b1, 32'(4*i), wd, 4'hF, 0, rd, er, lat, q, st, ra);
            nchk++; if (er !== 1'b0) begin nerr++; $display("FAIL fill0_w%0d err=%b want=0", i, er); end
        end
    endtask

    task automatic test_basic();
        logic [31:0] rd, erd; logic er, eer, ra; int lat; bit q, st;
        model(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, erd, eer);
        xact(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, q, st, ra);
        nchk++; if (lat != 3) begin nerr++; $display("FAIL basic_store_lat got=%0d want=3", lat); end
        nchk++; if (er !== 1'b0 || rd !== 32'h0) begin nerr++; $display("FAIL basic_store_resp err=%b rdata=%h want 0/0", er, rd); end
        nchk++; if (q !== 1'b1) begin nerr++; $display("FAIL basic_ready_busy got ready high while busy"); end
        xact(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, q, st, ra);
        nchk++; if (lat != 3) begin nerr++; $display("FAIL basic_load_lat got=%0d want=3", lat); end
        nchk++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin nerr++; $display("FAIL basic_load rdata=%h err=%b want deadbeef/0", rd, er); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd, erd; logic er, eer, ra; int lat; bit q, st;
        model(1'b0, 1'b1, 32'h10, 32'h11223344, 4'b0101, erd, eer);
        xact(1'b0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 0, rd, er, lat, q, st, ra);
        xact(1'b0, 1'b0, 32'h10, 32'h0, 4'b0000, 0, rd, er, lat, q, st, ra);
        nchk++; if (rd !== 32'hDE22BE44 || er !== 1'b0) begin nerr++; $display("FAIL lanes rdata=%h err=%b want de22be44/0", rd, er); end
        model(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, erd, eer);
        xact(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0, rd, er, lat, q, st, ra);
        nchk++; if (er !== 1'b0) begin nerr++; $display("FAIL lanes_noop_err got=%b want=0", er); end
        xact(1'b0, 1'b0, 32'h10, 32'h0, 4'b1010, 0, rd, er, lat, q, st, ra);
        nchk++; if (rd !== 32'hDE22BE44) begin nerr++; $display("FAIL lanes_noop rdata=%h want de22be44", rd); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd, erd; logic er, eer, ra; int lat; bit q, st;
        xact(1'b0, 1'b0, 32'h400, 32'h0, 4'hF, 0, rd, er, lat, q, st, ra);
        nchk++; if (er !== 1'b1 || rd !== 32'h0) begin nerr++; $display("FAIL oor_load err=%b rdata=%h want 1/0", er, rd); end
        nchk++; if (lat != 3) begin nerr++; $display("FAIL oor_lat got=%0d want=3", lat); end
        model(1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, 4'hF, erd, eer);
        xact(1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, 4'hF, 0, rd, er, lat, q, st, ra);
        nchk++; if (er !== 1'b1) begin nerr++; $display("FAIL oor_store err=%b want=1", er); end
        for (int i = 0; i < 256; i++) begin
            xact(1'b0, 1'b0, 32'(4*i), 32'h0, 4'h0, 0, rd, er, lat, q, st, ra);
            nchk++; if (rd !== mem1[i] || er !== 1'b0) begin nerr++; $display("FAIL oor_scan_w%0d rdata=%h want=%h", i, rd, mem1[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd, erd; logic er, eer, ra; int lat; bit q, st;
        logic [31:0] a;
        a = 32'(4 * $urandom_range(0, 255));
        model(1'b0, 1'b0, a, 32'h0, 4'h0, erd, eer);
        xact(1'b0, 1'b0, a, 32'h0, 4'h0, 5, rd, er, lat, q, st, ra);
        nchk++; if (st !== 1'b1) begin nerr++; $display("FAIL bp_stable got=0 want=1"); end
        nchk++; if (q !== 1'b1) begin nerr++; $display("FAIL bp_ready_low got=0 want=1"); end
        nchk++; if (ra !== 1'b1) begin nerr++; $display("FAIL bp_ready_after got=%b want=1", ra); end
        nchk++; if (rd !== erd) begin nerr++; $display("FAIL bp_rdata got=%h want=%h", rd, erd); end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rd, erd; logic er, eer, ra; int lat; bit q, st;
        @(negedge clk);
        sel = 1'b0; req_we = 1'b1; req_addr = 32'h20;
        req_wdata = ~mem1[8]; req_be = 4'hF; rv = 1'b1;
        #1;
        nchk++; if (r1_rdy !== 1'b1) begin nerr++; $display("FAIL rw_ready_idle got=%b want=1", r1_rdy); end
        @(posedge clk); #1;
        rv = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        nchk++; if (r1_tp !== 32'h0) begin nerr++; $display("FAIL rw_testport got=%h want=0", r1_tp); end
        nchk++; if (r1_vld !== 1'b0) begin nerr++; $display("FAIL rw_valid got=%b want=0", r1_vld); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        nchk++; if (r1_rdy !== 1'b1) begin nerr++; $display("FAIL rw_ready_release got=%b want=1", r1_rdy); end
        model(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, erd, eer);
        xact(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, q, st, ra);
        nchk++; if (rd !== erd || er !== 1'b0) begin nerr++; $display("FAIL rw_old_value rdata=%h want=%h", rd, erd); end
    endtask

    task automatic test_align();
        logic [31:0] rd, erd; logic er, eer, ra; int lat; bit q, st;
        model(1'b0, 1'b0, 32'h13, 32'h0, 4'h0, erd, eer);
        xact(1'b0, 1'b0, 32'h13, 32'h0, 4'h0, 0, rd, er, lat, q, st, ra);
`ifdef MIPS_DMEM_ALIGN_CHECK_EN
        nchk++; if (er !== 1'b1 || rd !== 32'h0) begin nerr++; $display("FAIL align err=%b rdata=%h want 1/0", er, rd); end
`else
        nchk++; if (er !== 1'b0 || rd !== mem1[4]) begin nerr++; $display("FAIL align err=%b rdata=%h want 0/%h", er, rd, mem1[4]); end
`endif
        nchk++; if (lat != 3 || rd !== erd || er !== eer) begin nerr++; $display("FAIL align_model lat=%0d rdata=%h err=%b", lat, rd, er); end
    endtask

    task automatic test_wait0();
        logic [31:0] rd, erd, wd; logic er, eer, ra; int lat; bit q, st;
        wd = $urandom;
        model(1'b1, 1'b1, 32'h8, wd, 4'hF, erd, eer);
        xact(1'b1, 1'b1, 32'h8, wd, 4'hF, 0, rd, er, lat, q, st, ra);
        nchk++; if (lat != 1) begin nerr++; $display("FAIL w0_store_lat got=%0d want=1", lat); end
        xact(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 0, rd, er, lat, q, st, ra);
        nchk++; if (lat != 1 || rd !== wd) begin nerr++; $display("FAIL w0_load lat=%0d rdata=%h want 1/%h", lat, rd, wd); end
        xact(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 0, rd, er, lat, q, st, ra);
        nchk++; if (er !== 1'b1 || rd !== 32'h0) begin nerr++; $display("FAIL w0_oor err=%b rdata=%h want 1/0", er, rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, a, wd; logic er, eer, ra; int lat, depth; bit q, st, s, we;
        logic [3:0] b;
        for (int k = 0; k < 150; k++) begin
            s = 1'($urandom); we = 1'($urandom);
            depth = s ? 16 : 256;
            case ($urandom_range(0, 3))
                0, 1:    a = 32'($urandom_range(0, depth - 1)) << 2;
                2:       a = 32'($urandom_range(0, 4 * depth - 1));
                default: a = 32'(4 * depth) + 32'($urandom_range(0, 5000));
            endcase
            wd = $urandom; b = 4'($urandom);
            model(s, we, a, wd, b, erd, eer);
            xact(s, we, a, wd, b, $urandom_range(0, 3), rd, er, lat, q, st, ra);
            nchk++; if (rd !== erd || er !== eer) begin nerr++; $display("FAIL rnd%0d a=%h we=%b rdata=%h err=%b want %h/%b", k, a, we, rd, er, erd, eer); end
            nchk++; if (lat != (s ? 1 : 3) || q !== 1'b1 || st !== 1'b1 || ra !== 1'b1) begin nerr++; $display("FAIL rnd%0d_timing lat=%0d quiet=%b stable=%b ready_after=%b", k, lat, q, st, ra); end
            nchk++; if (tp_m !== a) begin nerr++; $display("FAIL rnd%0d_testport got=%h want=%h", k, tp_m, a); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fill();
        test_basic();
        test_byte_lanes();
        test_out_of_range();
        test_backpressure();
        test_reset_in_wait();
        test_align();
        test_wait0();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
